// File: rtl/score_evaluation_multi.sv
// Whack-a-mole scorer: judges one guess per mole window, keeps a saturating score,
// miss and streak counters. Optional define STREAK_BONUS_EN enables the streak bonus.
module score_evaluation_multi #(
  parameter int unsigned NUM_HOLES       = 8,
  parameter int unsigned POS_W           = 3,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned MISS_W          = 4,
  parameter int unsigned PENALTY         = 0,
  parameter int unsigned MISS_ON_TIMEOUT = 1,
  parameter int unsigned STREAK_THRESH   = 3,
  parameter int unsigned BONUS           = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   user_guess,
  input  logic               eval_now,
  input  logic [POS_W-1:0]   mole_pos,
  input  logic               mole_change,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  miss_count,
  output logic [3:0]         streak,
  output logic               guess_now,
  output logic               guess_correct,
  output logic               guess_wrong
);

`ifdef STREAK_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

  typedef enum logic [1:0] {
    ARMED,
    HIT,
    MISS
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [3:0]         streak_q, streak_d;
  logic               guess_now_q, guess_correct_q, guess_wrong_q;

  logic        pos_valid;
  logic        take_hit, take_miss;
  logic [31:0] score_ext, hit_add, hit_sum;

  // Positions beyond the last hole only exist when the bus is wider than needed.
  if (NUM_HOLES >= (1 << POS_W)) begin : g_all_valid
    assign pos_valid = 1'b1;
  end else begin : g_range_check
    assign pos_valid = (32'(mole_pos) < NUM_HOLES);
  end

  always_comb begin
    state_d   = state_q;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    case (state_q)
      ARMED: begin
        // mole_change has priority: a coincident guess belongs to the old mole and is dropped.
        if (mole_change) begin
          take_miss = (MISS_ON_TIMEOUT != 0);
        end else if (eval_now) begin
          if ((user_guess == mole_pos) && pos_valid) begin
            take_hit = 1'b1;
            state_d  = HIT;
          end else begin
            take_miss = 1'b1;
            state_d   = MISS;
          end
        end
      end
      HIT, MISS: begin
        if (mole_change) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    score_ext = 32'(score_q);
    hit_add   = (BONUS_EN && ((32'(streak_q) + 32'd1) >= STREAK_THRESH)) ? (32'd1 + BONUS) : 32'd1;
    hit_sum   = score_ext + hit_add;
    score_d   = score_q;
    miss_d    = miss_q;
    streak_d  = streak_q;
    if (take_hit) begin
      score_d  = (hit_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(hit_sum);
      streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
    end else if (take_miss) begin
      score_d  = (score_ext < PENALTY) ? '0 : SCORE_W'(score_ext - PENALTY);
      miss_d   = (miss_q == '1) ? miss_q : miss_q + 1'b1;
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ARMED;
      score_q         <= '0;
      miss_q          <= '0;
      streak_q        <= '0;
      guess_now_q     <= 1'b1;
      guess_correct_q <= 1'b0;
      guess_wrong_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      score_q         <= score_d;
      miss_q          <= miss_d;
      streak_q        <= streak_d;
      guess_now_q     <= (state_d == ARMED);
      guess_correct_q <= take_hit;
      guess_wrong_q   <= (state_d == MISS);
    end
  end

  assign score         = score_q;
  assign miss_count    = miss_q;
  assign streak        = streak_q;
  assign guess_now     = guess_now_q;
  assign guess_correct = guess_correct_q;
  assign guess_wrong   = guess_wrong_q;

endmodule

// File: tb/tb_score_evaluation_multi.sv
// Bench for score_evaluation_multi: two parameterisations driven by the same stimulus,
// each compared against a window/lockout reference model.
module tb_score_evaluation_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] user_guess;
  logic       eval_now;
  logic [2:0] mole_pos;
  logic       mole_change;

  logic [7:0] score_a;
  logic [3:0] miss_a;
  logic [3:0] streak_a;
  logic       now_a, corr_a, wrong_a;

  logic [3:0] score_b;
  logic [2:0] miss_b;
  logic [3:0] streak_b;
  logic       now_b, corr_b, wrong_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_evaluation_multi u_a (
    .clk(clk), .rst(rst), .user_guess(user_guess), .eval_now(eval_now),
    .mole_pos(mole_pos), .mole_change(mole_change),
    .score(score_a), .miss_count(miss_a), .streak(streak_a),
    .guess_now(now_a), .guess_correct(corr_a), .guess_wrong(wrong_a)
  );

  score_evaluation_multi #(
    .NUM_HOLES(6), .POS_W(3), .SCORE_W(4), .MISS_W(3),
    .PENALTY(2), .MISS_ON_TIMEOUT(0), .STREAK_THRESH(3), .BONUS(1)
  ) u_b (
    .clk(clk), .rst(rst), .user_guess(user_guess), .eval_now(eval_now),
    .mole_pos(mole_pos), .mole_change(mole_change),
    .score(score_b), .miss_count(miss_b), .streak(streak_b),
    .guess_now(now_b), .guess_correct(corr_b), .guess_wrong(wrong_b)
  );

  // Reference model: window is open, closed by a hit, or closed by a miss.
  localparam int OPEN = 0, DONE_HIT = 1, DONE_MISS = 2;
  int P_NH[2]   = '{8, 6};
  int P_SMAX[2] = '{255, 15};
  int P_MMAX[2] = '{15, 7};
  int P_PEN[2]  = '{0, 2};
  int P_TO[2]   = '{1, 0};
  int P_THR     = 3;
  int P_BON     = 1;

  int m_score[2], m_miss[2], m_streak[2], m_phase[2];
  int m_corr[2];

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_miss[k] = 0; m_streak[k] = 0;
      m_phase[k] = OPEN; m_corr[k] = 0;
    end
  endtask

  task automatic model_miss(input int k);
    m_score[k]  = (m_score[k] > P_PEN[k]) ? m_score[k] - P_PEN[k] : 0;
    m_miss[k]   = imin(m_miss[k] + 1, P_MMAX[k]);
    m_streak[k] = 0;
  endtask

  task automatic model_step(input bit ev, input bit mc, input int g, input int p);
    int add;
    for (int k = 0; k < 2; k++) begin
      m_corr[k] = 0;
      if (mc) begin
        if (m_phase[k] == OPEN && P_TO[k] != 0) model_miss(k);
        m_phase[k] = OPEN;
      end else if (ev && m_phase[k] == OPEN) begin
        if (g == p && p < P_NH[k]) begin
          add = 1;
`ifdef STREAK_BONUS_EN
          if (m_streak[k] >= P_THR - 1) add = 1 + P_BON;
`endif
          m_score[k]  = imin(m_score[k] + add, P_SMAX[k]);
          m_streak[k] = imin(m_streak[k] + 1, 15);
          m_phase[k]  = DONE_HIT;
          m_corr[k]   = 1;
        end else begin
          model_miss(k);
          m_phase[k] = DONE_MISS;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.score",   32'(score_a),  32'(m_score[0]));
    chk("a.miss",    32'(miss_a),   32'(m_miss[0]));
    chk("a.streak",  32'(streak_a), 32'(m_streak[0]));
    chk("a.now",     32'(now_a),    32'(m_phase[0] == OPEN));
    chk("a.correct", 32'(corr_a),   32'(m_corr[0]));
    chk("a.wrong",   32'(wrong_a),  32'(m_phase[0] == DONE_MISS));
    chk("b.score",   32'(score_b),  32'(m_score[1]));
    chk("b.miss",    32'(miss_b),   32'(m_miss[1]));
    chk("b.streak",  32'(streak_b), 32'(m_streak[1]));
    chk("b.now",     32'(now_b),    32'(m_phase[1] == OPEN));
    chk("b.correct", 32'(corr_b),   32'(m_corr[1]));
    chk("b.wrong",   32'(wrong_b),  32'(m_phase[1] == DONE_MISS));
  endtask

  // Inputs change at the falling edge, the model advances at the rising edge,
  // outputs are compared at the following falling edge.
  task automatic step(input bit ev, input bit mc, input int g, input int p);
    eval_now    = ev;
    mole_change = mc;
    user_guess  = 3'(g);
    mole_pos    = 3'(p);
    @(posedge clk);
    model_step(ev, mc, g, p);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int g, p;
    bit ev, mc;
    rst = 1'b0; eval_now = 1'b0; mole_change = 1'b0; user_guess = '0; mole_pos = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;

    // Hit, then the pulse drops and further guesses are ignored.
    step(1, 0, 5, 5);
    step(0, 0, 5, 5);
    step(1, 0, 5, 5);
    step(0, 1, 0, 2);
    // Wrong guess, second guess ignored, mole_change re-arms.
    step(1, 0, 6, 2);
    step(1, 0, 2, 2);
    step(0, 1, 0, 6);
    // Position 6 is a hole for u_a but out of range for u_b.
    step(1, 0, 6, 6);
    step(0, 1, 0, 3);
    // Correct guess coinciding with mole_change: change wins.
    step(1, 1, 3, 3);
    // Plain timeout.
    step(0, 1, 0, 4);
    // Score and streak saturation.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, i % 6, i % 6);
      step(0, 1, 0, 0);
    end
    // Penalty floor and miss counter saturation.
    for (int i = 0; i < 18; i++) begin
      step(1, 0, 7, 1);
      step(0, 1, 0, 0);
    end
    // Random traffic, guesses biased toward the mole.
    for (int i = 0; i < 400; i++) begin
      p  = int'($urandom_range(0, 7));
      g  = ($urandom_range(0, 1) == 0) ? p : int'($urandom_range(0, 7));
      ev = ($urandom_range(0, 9) < 4);
      mc = ($urandom_range(0, 9) < 2);
      step(ev, mc, g, p);
    end

    async_reset_check();
    // Score 7, then lock out on a miss and reset asynchronously inside the window.
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 1, 1);
      step(0, 1, 0, 1);
    end
    step(1, 0, 0, 1);
    chk("a.score_before_reset", 32'(score_a), 32'd7);
    async_reset_check();
    // Reset arriving right after a hit edge loses the pulse.
    step(1, 0, 4, 4);
    async_reset_check();
    step(1, 0, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
